// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register-hazard scoreboard and the decode that feeds it.
package hazard_scoreboard_pkg;

    localparam int SB_AW   = 6;
    localparam int SB_PROT = 4;

    // Opcode classes used by decode to derive iss_writes / iss_late
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_BR  = 4'h5;

    typedef struct packed {
        logic             v;
        logic [SB_AW-1:0] addr;
        logic             late;
    } entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority encoder: finds the lowest stage whose valid entry writes the operand.
module scoreboard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SW    = 2
) (
    input  entry_t           entries [DEPTH],
    input  logic [SB_AW-1:0] opAddr,
    input  logic             opUsed,
    output logic             hit,
    output logic [SW-1:0]    stage,
    output logic             avail
);

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        avail = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (opUsed && entries[k].v && entries[k].addr == opAddr) begin
                hit   = 1'b1;
                stage = SW'(k + 1);
                avail = !entries[k].late || (k == DEPTH - 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and resolves stall / forwarding for the instruction at register read.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW     = SB_AW,
    parameter int DEPTH  = 3,
    parameter int PROT   = SB_PROT,
    parameter int FWD_EN = 1,
    parameter int SW     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_s,
    input  logic [AW-1:0]    iss_d,
    input  logic             iss_uses_s,
    input  logic             iss_uses_d,
    input  logic             iss_writes,
    input  logic             iss_late,
    input  logic             flush,
    input  logic [DEPTH-1:0] flush_mask,
    output logic             stall,
    output logic             iss_accept,
    output logic [SW-1:0]    fwd_s_sel,
    output logic [SW-1:0]    fwd_d_sel,
    output logic [SW-1:0]    occupancy,
    output logic [15:0]      stall_cycles
);

    localparam logic [AW-1:0] PROT_ADDR = AW'(PROT);

    entry_t entries [DEPTH];

    logic          sUse, dUse, sHit, dHit, sAvail, dAvail, issue, retire;
    logic [SW-1:0] sStage, dStage, killCount;
    logic [DEPTH-1:0] killed;

    assign sUse = iss_valid && iss_uses_s && (iss_s >= PROT_ADDR);
    assign dUse = iss_valid && iss_uses_d && (iss_d >= PROT_ADDR);

    scoreboard_match #(.DEPTH(DEPTH), .SW(SW)) matchS (
        .entries(entries), .opAddr(SB_AW'(iss_s)), .opUsed(sUse),
        .hit(sHit), .stage(sStage), .avail(sAvail)
    );

    scoreboard_match #(.DEPTH(DEPTH), .SW(SW)) matchD (
        .entries(entries), .opAddr(SB_AW'(iss_d)), .opUsed(dUse),
        .hit(dHit), .stage(dStage), .avail(dAvail)
    );

    // Handshake: the instruction at register read leaves it in a cycle with iss_valid & iss_accept;
    // stall or flush holds it there, and the decision depends only on current entries and iss_* inputs.
    always_comb begin
        if (FWD_EN != 0) stall = (sHit && !sAvail) || (dHit && !dAvail);
        else             stall = sHit || dHit;
        iss_accept = iss_valid && !stall && !flush;
        fwd_s_sel  = (FWD_EN != 0 && sHit && !stall) ? sStage : '0;
        fwd_d_sel  = (FWD_EN != 0 && dHit && !stall) ? dStage : '0;
        issue      = iss_accept && iss_writes && (iss_d >= PROT_ADDR);
    end

    // A killed write-back entry is excluded from retire so it is only subtracted once
    always_comb begin
        killCount = '0;
        for (int k = 0; k < DEPTH; k++) begin
            killed[k] = flush && flush_mask[k] && entries[k].v;
            killCount = killCount + SW'(killed[k]);
        end
        retire = entries[DEPTH-1].v && !killed[DEPTH-1];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
            occupancy    <= '0;
            stall_cycles <= '0;
        end else begin
            entries[0] <= issue ? {1'b1, SB_AW'(iss_d), iss_late} : '0;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= killed[k-1] ? '0 : entries[k-1];
            end
            occupancy <= occupancy + SW'(issue) - SW'(retire) - killCount;
            if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding and non-forwarding builds share one stimulus stream.
module tb_hazard_scoreboard;

    localparam int AW    = 6;
    localparam int DEPTH = 3;
    localparam int SW    = 2;
    localparam int W     = 25;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             issValid = 1'b0, issUsesS = 1'b0, issUsesD = 1'b0;
    logic             issWrites = 1'b0, issLate = 1'b0, flush = 1'b0;
    logic [AW-1:0]    issS = '0, issD = '0;
    logic [DEPTH-1:0] flushMask = '0;

    logic          stall0, accept0, stall1, accept1;
    logic [SW-1:0] fwdS0, fwdD0, occ0, fwdS1, fwdD1, occ1;
    logic [15:0]   sc0, sc1;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .PROT(4), .FWD_EN(1), .SW(SW)) dutFwd (
        .clock(clock), .reset(reset), .iss_valid(issValid), .iss_s(issS), .iss_d(issD),
        .iss_uses_s(issUsesS), .iss_uses_d(issUsesD), .iss_writes(issWrites), .iss_late(issLate),
        .flush(flush), .flush_mask(flushMask), .stall(stall0), .iss_accept(accept0),
        .fwd_s_sel(fwdS0), .fwd_d_sel(fwdD0), .occupancy(occ0), .stall_cycles(sc0)
    );

    hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .PROT(4), .FWD_EN(0), .SW(SW)) dutNoFwd (
        .clock(clock), .reset(reset), .iss_valid(issValid), .iss_s(issS), .iss_d(issD),
        .iss_uses_s(issUsesS), .iss_uses_d(issUsesD), .iss_writes(issWrites), .iss_late(issLate),
        .flush(flush), .flush_mask(flushMask), .stall(stall1), .iss_accept(accept1),
        .fwd_s_sel(fwdS1), .fwd_d_sel(fwdD1), .occupancy(occ1), .stall_cycles(sc1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle of inputs and, when chk=1, queue the outputs expected for that cycle.
    // Record layout: {dut, stall, accept, fwdS, fwdD, occupancy, stall_cycles}
    task automatic step(input logic rst, input logic valid, input logic [AW-1:0] s, input logic us,
                        input logic [AW-1:0] d, input logic ud, input logic wr, input logic late,
                        input logic fl, input logic [DEPTH-1:0] mask, input logic chk, input logic dut,
                        input logic eStall, input logic eAcc, input logic [SW-1:0] eFs,
                        input logic [SW-1:0] eFd, input logic [SW-1:0] eOcc, input logic [15:0] eSc);
        @(posedge clock);
        #1;
        reset = rst; issValid = valid; issS = s; issUsesS = us; issD = d; issUsesD = ud;
        issWrites = wr; issLate = late; flush = fl; flushMask = mask;
        if (chk) exp_q.push_back({dut, eStall, eAcc, eFs, eFd, eOcc, eSc});
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[24]) begin
                check("nofwd_stall", 16'(stall1), 16'(e[23]));
                check("nofwd_accept", 16'(accept1), 16'(e[22]));
                check("nofwd_fwd_s", 16'(fwdS1), 16'(e[21:20]));
                check("nofwd_fwd_d", 16'(fwdD1), 16'(e[19:18]));
                check("nofwd_occupancy", 16'(occ1), 16'(e[17:16]));
                check("nofwd_stall_cycles", sc1, e[15:0]);
            end else begin
                check("fwd_stall", 16'(stall0), 16'(e[23]));
                check("fwd_accept", 16'(accept0), 16'(e[22]));
                check("fwd_fwd_s", 16'(fwdS0), 16'(e[21:20]));
                check("fwd_fwd_d", 16'(fwdD0), 16'(e[19:18]));
                check("fwd_occupancy", 16'(occ0), 16'(e[17:16]));
                check("fwd_stall_cycles", sc0, e[15:0]);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: run did not finish, queue holds %0d", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Clock/reset block plus directed stimulus
    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clock);
        // reset held with a valid writing instruction: nothing tracked, accept follows the formula
        step(0,1, 5,1, 6,1,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        step(0,1, 5,1, 6,1,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        // back-to-back ALU RAW on r5 through every stage
        step(1,1, 0,0, 5,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        step(1,1, 5,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,1,0,1,16'd0);
        step(1,1, 5,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,2,0,1,16'd0);
        step(1,1, 5,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,3,0,1,16'd0);
        step(1,1, 5,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        // load-use on r9: two stall cycles, then write-back forward
        step(1,1, 0,0, 9,0,1,1, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        step(1,1, 9,1, 0,0,0,0, 0,3'b000, 1,0, 1,0,0,0,1,16'd0);
        step(1,1, 9,1, 0,0,0,0, 0,3'b000, 1,0, 1,0,0,0,1,16'd1);
        step(1,1, 9,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,3,0,1,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,0,16'd2);
        // protected r2 write ignored; youngest of two r7 writes wins
        step(1,1, 0,0, 2,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd2);
        step(1,1, 0,0, 7,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd2);
        step(1,1, 0,0, 7,0,1,0, 0,3'b000, 1,0, 0,1,0,0,1,16'd2);
        step(1,1, 2,1, 7,1,0,0, 0,3'b000, 1,0, 0,1,0,1,2,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,2,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,1,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,0,16'd2);
        // fill r7/r6/r5 then flush stages 1-2 with a valid writer present
        step(1,1, 0,0, 7,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd2);
        step(1,1, 0,0, 6,0,1,0, 0,3'b000, 1,0, 0,1,0,0,1,16'd2);
        step(1,1, 0,0, 5,0,1,0, 0,3'b000, 1,0, 0,1,0,0,2,16'd2);
        step(1,1, 20,1, 21,1,1,0, 1,3'b011, 1,0, 0,0,0,0,3,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,0,16'd2);
        // refill then flush stage 1 only
        step(1,1, 0,0, 7,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd2);
        step(1,1, 0,0, 6,0,1,0, 0,3'b000, 1,0, 0,1,0,0,1,16'd2);
        step(1,1, 0,0, 5,0,1,0, 0,3'b000, 1,0, 0,1,0,0,2,16'd2);
        step(1,0, 0,0, 0,0,0,0, 1,3'b001, 1,0, 0,0,0,0,3,16'd2);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,1,16'd2);
        // stalled load-use flushed away: next cycle sees no hazard
        step(1,1, 0,0, 9,0,1,1, 0,3'b000, 1,0, 0,1,0,0,0,16'd2);
        step(1,1, 9,1, 0,0,0,0, 1,3'b001, 1,0, 1,0,0,0,1,16'd2);
        step(1,1, 9,1, 0,0,0,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd3);
        // same register on both operands
        step(1,1, 0,0, 12,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd3);
        step(1,1, 12,1, 12,1,0,0, 0,3'b000, 1,0, 0,1,1,1,1,16'd3);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,1,16'd3);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,1,16'd3);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 1,0, 0,0,0,0,0,16'd3);
        // reset mid-operation discards tracked and simultaneously issued writes
        step(1,1, 0,0, 13,0,1,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd3);
        step(0,1, 0,0, 14,0,1,0, 0,3'b000, 1,0, 0,1,0,0,1,16'd3);
        step(1,1, 13,1, 14,1,0,0, 0,3'b000, 1,0, 0,1,0,0,0,16'd0);
        // non-forwarding build: any match stalls until the writer retires
        step(0,0, 0,0, 0,0,0,0, 0,3'b000, 0,1, 0,0,0,0,0,16'd0);
        step(0,0, 0,0, 0,0,0,0, 0,3'b000, 1,1, 0,0,0,0,0,16'd0);
        step(1,1, 0,0, 10,0,1,0, 0,3'b000, 1,1, 0,1,0,0,0,16'd0);
        step(1,1, 10,1, 0,0,0,0, 0,3'b000, 1,1, 1,0,0,0,1,16'd0);
        step(1,1, 10,1, 0,0,0,0, 0,3'b000, 1,1, 1,0,0,0,1,16'd1);
        step(1,1, 10,1, 0,0,0,0, 0,3'b000, 1,1, 1,0,0,0,1,16'd2);
        step(1,1, 10,1, 0,0,0,0, 0,3'b000, 1,1, 0,1,0,0,0,16'd3);
        step(1,0, 0,0, 0,0,0,0, 0,3'b000, 0,0, 0,0,0,0,0,16'd0);
        repeat (2) @(posedge clock);
        check("queue_drain", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
